// File: rtl/jt12_pcm_pkg.sv
// Shared definitions for the YM2612 DAC feeder: register addresses,
// sequencer states and the unsigned-byte to signed-sample conversion.
package jt12_pcm_pkg;

    localparam logic [7:0] REG_DAC    = 8'h2A;
    localparam logic [7:0] REG_DACEN  = 8'h2B;
    localparam logic [7:0] REG_DACLSB = 8'h2C;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } pcm_state_e;

    // Flipping the MSB turns the offset-binary DAC byte into two's complement;
    // the extra LSB from register 0x2C extends it to 9 bits.
    function automatic logic [8:0] pcm_convert(input logic [7:0] data, input logic lsb);
        return {~data[7], data[6:0], lsb};
    endfunction

endpackage

// File: rtl/jt12_pcm_fifo.sv
// Small synchronous FIFO that buffers DAC samples between bursty CPU writes
// and the paced sequencer. A push into a full FIFO succeeds only when a pop
// frees a slot in the same cycle; flush empties it and overrides push/pop.
module jt12_pcm_fifo #(
    parameter int W  = 9,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = level_q[AW];
    assign empty_o = (level_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at 2^AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + {{AW{1'b0}}, 1'b1};
            end else if (do_pop && !do_push) begin
                level_q <= level_q - {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Sample storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/jt12_pcm_feeder.sv
// YM2612 DAC feeder: decodes CPU writes to 0x2A/0x2B/0x2C, converts the
// DAC byte to a signed 9-bit sample and replays buffered samples to the
// interpolator as pcm_wr/pcmout strobes of STRB_LEN cen ticks, each followed
// by a gap containing at least one cen55 tick.
// Build option JT12_PCM_FIFO_EN: when defined, samples are buffered in a
// 2^FIFO_AW deep FIFO; otherwise a single pending register (latest wins).
module jt12_pcm_feeder import jt12_pcm_pkg::*; #(
    parameter int DW       = 9,
    parameter int FIFO_AW  = 2,
    parameter int STRB_LEN = 4
) (
    input  logic               rst_n,
    input  logic               clk,
    input  logic               cen,
    input  logic               cen55,
    input  logic               write,
    input  logic [1:0]         addr,
    input  logic [7:0]         din,
    output logic               pcm_en,
    output logic               pcm_wr,
    output logic [DW-1:0]      pcmout,
    output logic               overrun,
    output logic [FIFO_AW:0]   level
);

    localparam logic [3:0] CNT_LAST = 4'(STRB_LEN - 1);

    logic [7:0]    addr_q, addr_d;
    logic          lsb_q, lsb_d;
    logic          pcm_en_q, pcm_en_d;
    logic          overrun_q, overrun_d;
    logic          pcm_wr_q;
    logic [DW-1:0] pcmout_q;
    logic [3:0]    cnt_q;
    pcm_state_e    state_q;

    logic          addr_wr;
    logic          data_wr;
    logic          dac_wr;
    logic          en_wr;
    logic          lsb_wr;
    logic          push;
    logic          pop;
    logic          flush;
    logic          lost;
    logic          empty;
    logic [DW-1:0] sample;
    logic [DW-1:0] head;

    assign addr_wr = write && !addr[1] && !addr[0];
    assign data_wr = write && !addr[1] &&  addr[0];
    assign dac_wr  = data_wr && (addr_q == REG_DAC);
    assign en_wr   = data_wr && (addr_q == REG_DACEN);
    assign lsb_wr  = data_wr && (addr_q == REG_DACLSB);

    assign sample  = pcm_convert(din, lsb_q);
    assign push    = dac_wr && pcm_en_q;
    assign flush   = en_wr && pcm_en_q && !din[7];
    assign pop     = (state_q == IDLE) && pcm_en_q && !empty && !flush;

`ifdef JT12_PCM_FIFO_EN
    logic full;

    jt12_pcm_fifo #(
        .W  (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .din_i   (sample),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign lost = push && full && !pop;
`else
    logic          pend_valid_q;
    logic [DW-1:0] pend_data_q;

    // Single pending sample: a new write replaces an unconsumed one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else if (flush) begin
            pend_valid_q <= 1'b0;
        end else if (push) begin
            pend_valid_q <= 1'b1;
            pend_data_q  <= sample;
        end else if (pop) begin
            pend_valid_q <= 1'b0;
        end
    end

    assign head  = pend_data_q;
    assign empty = !pend_valid_q;
    assign level = {{FIFO_AW{1'b0}}, pend_valid_q};
    assign lost  = push && pend_valid_q && !pop;
`endif

    // Next-state for the CPU-visible registers; a 0x2B write also clears overrun.
    always_comb begin
        addr_d    = addr_q;
        lsb_d     = lsb_q;
        pcm_en_d  = pcm_en_q;
        overrun_d = overrun_q;
        if (addr_wr) begin
            addr_d = din;
        end
        if (lsb_wr) begin
            lsb_d = din[3];
        end
        if (en_wr) begin
            pcm_en_d  = din[7];
            overrun_d = 1'b0;
        end else if (lost) begin
            overrun_d = 1'b1;
        end
    end

    // CPU-visible register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            lsb_q     <= 1'b0;
            pcm_en_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            lsb_q     <= lsb_d;
            pcm_en_q  <= pcm_en_d;
            overrun_q <= overrun_d;
        end
    end

    // Sequencer: load a sample, hold pcm_wr for STRB_LEN cen ticks, then wait
    // for a fresh cen55 before the next sample. Disabling aborts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pcm_wr_q <= 1'b0;
            pcmout_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            state_q  <= IDLE;
            pcm_wr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        pcmout_q <= head;
                        pcm_wr_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= STROBE;
                    end
                end
                STROBE: begin
                    if (cen) begin
                        if (cnt_q == CNT_LAST) begin
                            pcm_wr_q <= 1'b0;
                            state_q  <= GAP;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (cen55) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    pcm_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign pcm_en  = pcm_en_q;
    assign pcm_wr  = pcm_wr_q;
    assign pcmout  = pcmout_q;
    assign overrun = overrun_q;

endmodule
